// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage feeding decode.
// Issues word-aligned reads to instruction memory, buffers returned words
// in a 2-entry FIFO of {instr, pc_plus4}, and flushes on redirect.
// Optional feature macro: FETCH_PERF_CNT_EN adds the stall_cnt output.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;

    // FIFO storage: entry 0 is always the head, entry 1 the tail
    logic [31:0] r_e0_instr;
    logic [31:0] r_e0_pp4;
    logic [31:0] r_e1_instr;
    logic [31:0] r_e1_pp4;
    logic [1:0]  r_count;

    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_pp4;
    logic [31:0] w_redirect_aligned;

    assign if_valid           = (r_count != 2'd0);
    assign if_instr           = r_e0_instr;
    assign if_pc_plus4        = r_e0_pp4;
    assign w_push_pp4         = r_req_pc + 32'd4;
    assign w_redirect_aligned = redirect_pc & ~32'd3;
    // A redirect cancels any transfer to decode in the same cycle
    assign w_pop              = if_valid & id_ready & ~redirect_valid;

    // Next-state and request/push decode; redirect dominates every state
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_ISSUE: begin
                if (!redirect_valid && !rst && (r_count < 2'd2)) begin
                    w_issue      = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_next_state = imem_rvalid ? S_ISSUE : S_DISCARD;
                end else if (imem_rvalid) begin
                    w_push       = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_DISCARD: begin
                // The stale response is dropped even if a new redirect arrives with it
                if (imem_rvalid) begin
                    w_next_state = S_ISSUE;
                end
            end
            default: begin
                w_next_state = S_ISSUE;
            end
        endcase
    end

    assign imem_req  = w_issue;
    assign imem_addr = w_issue ? r_pc : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fetch pointer and address of the outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_aligned;
        end else if (w_issue) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
        end
    end

    // Output FIFO: shift-style so the head is always a plain register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0_instr <= '0;
            r_e0_pp4   <= '0;
            r_e1_instr <= '0;
            r_e1_pp4   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_e0_instr <= imem_rdata;
                        r_e0_pp4   <= w_push_pp4;
                        r_count    <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_e1_instr <= imem_rdata;
                        r_e1_pp4   <= w_push_pp4;
                        r_count    <= 2'd2;
                    end
                end
                2'b01: begin
                    r_e0_instr <= r_e1_instr;
                    r_e0_pp4   <= r_e1_pp4;
                    r_count    <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push and pop together: count is unchanged, data moves one slot
                    if (r_count == 2'd1) begin
                        r_e0_instr <= imem_rdata;
                        r_e0_pp4   <= w_push_pp4;
                    end else begin
                        r_e0_instr <= r_e1_instr;
                        r_e0_pp4   <= r_e1_pp4;
                        r_e1_instr <= imem_rdata;
                        r_e1_pp4   <= w_push_pp4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Saturating count of cycles where decode was ready but starved
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (id_ready && !if_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
